ps2_key_rx: RTL

PS2_KEY_RX -- requirements
Module: ps2_key_rx

---
 rtl/ps2_key_rx.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the keyboard clock, deframes
// 11-bit frames and turns scan-code sequences (E0/F0 prefixes) into key events.
module ps2_key_rx #(
   parameter int FILT_LEN = 8,
   parameter int TIMEOUT  = 24000
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err,
   output logic        busy
);

   localparam int FW = $clog2(FILT_LEN) + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FILT_MAX = FW'(FILT_LEN);
   localparam logic [FW-1:0] FILT_ONE = FW'(1);
   localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);
   localparam logic [TW-1:0] TO_ONE   = TW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   // Frame is valid when data bits plus parity hold an odd number of ones.
   function automatic logic odd_ok(input logic [7:0] b, input logic p);
      odd_ok = ^{b, p};
   endfunction

   function automatic logic is_status(input logic [7:0] b);
      case (b)
         8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF: is_status = 1'b1;
         default:                           is_status = 1'b0;
      endcase
   endfunction

   logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] filt_cnt_q, filt_cnt_d;
   logic          strobe_s;
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          ext_q, ext_d, rel_q, rel_d;
   logic [10:0]   key_q, key_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;

   // Glitch filter: the filtered clock follows only a sustained level change.
   always_comb begin
      filt_d     = filt_q;
      filt_cnt_d = filt_cnt_q;
      if (clk_s2_q != filt_q) begin
         if (filt_cnt_q == FILT_MAX - FILT_ONE) begin
            filt_d     = clk_s2_q;
            filt_cnt_d = '0;
         end else begin
            filt_cnt_d = filt_cnt_q + FILT_ONE;
         end
      end else begin
         filt_cnt_d = '0;
      end
   end

   assign strobe_s = filt_q & ~filt_d;

   // Frame FSM, prefix flags, event generation and timeout supervision.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      to_cnt_d  = to_cnt_q;
      ext_d     = ext_q;
      rel_d     = rel_q;
      key_d     = key_q;
      err_d     = 1'b0;
      case (state_q)
         IDLE: begin
            to_cnt_d = '0;
            if (strobe_s) begin
               if (!dat_s2_q) begin
                  state_d   = DATA;
                  bit_cnt_d = 3'd0;
               end else begin
                  err_d = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DATA: begin
            if (strobe_s) begin
               shift_d   = {dat_s2_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = PARITY;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
         PARITY: begin
            if (strobe_s) begin
               par_d   = dat_s2_q;
               state_d = STOP;
            end else begin
               state_d = PARITY;
            end
         end
         STOP: begin
            if (strobe_s) begin
               state_d = IDLE;
               if (dat_s2_q && odd_ok(shift_q, par_q)) begin
                  if (shift_q == 8'hE0) begin
                     ext_d = 1'b1;
                  end else if (shift_q == 8'hF0) begin
                     rel_d = 1'b1;
                  end else if (is_status(shift_q)) begin
                     ext_d = 1'b0;
                     rel_d = 1'b0;
                  end else begin
                     key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                     ext_d = 1'b0;
                     rel_d = 1'b0;
                  end
               end else begin
                  err_d = 1'b1;
                  ext_d = 1'b0;
                  rel_d = 1'b0;
               end
            end else begin
               state_d = STOP;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A strobe in the same cycle as expiry wins: it has already advanced the FSM.
      if (state_q != IDLE) begin
         if (strobe_s) begin
            to_cnt_d = '0;
         end else if (to_cnt_q + TO_ONE == TO_MAX) begin
            to_cnt_d = '0;
            state_d  = IDLE;
            ext_d    = 1'b0;
            rel_d    = 1'b0;
            err_d    = 1'b1;
         end else begin
            to_cnt_d = to_cnt_q + TO_ONE;
         end
      end else begin
         to_cnt_d = '0;
      end

      busy_d = (state_d != IDLE);
   end

   // State and output registers; synchronizers and filtered clock idle high.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         clk_s1_q   <= 1'b1;
         clk_s2_q   <= 1'b1;
         dat_s1_q   <= 1'b1;
         dat_s2_q   <= 1'b1;
         filt_q     <= 1'b1;
         filt_cnt_q <= '0;
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         shift_q    <= 8'h00;
         par_q      <= 1'b0;
         to_cnt_q   <= '0;
         ext_q      <= 1'b0;
         rel_q      <= 1'b0;
         key_q      <= 11'h000;
         err_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         clk_s1_q   <= ps2_clk;
         clk_s2_q   <= clk_s1_q;
         dat_s1_q   <= ps2_data;
         dat_s2_q   <= dat_s1_q;
         filt_q     <= filt_d;
         filt_cnt_q <= filt_cnt_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         to_cnt_q   <= to_cnt_d;
         ext_q      <= ext_d;
         rel_q      <= rel_d;
         key_q      <= key_d;
         err_q      <= err_d;
         busy_q     <= busy_d;
      end
   end

   assign ps2_key   = key_q;
   assign frame_err = err_q;
   assign busy      = busy_q;

endmodule
